// File: rtl/psram_arbiter.sv
// psram_arbiter: fixed-priority (A over B) arbiter in front of a single PSRAM
// byte-access controller, with a starvation limit that grants B after
// MAX_A_RUN consecutive A grants while B is waiting. One transaction in flight.
// Optional build macro PSRAM_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// acks the requester with 8'hFF and pulses o_timeout if the controller never
// reports done.
module psram_arbiter #(
   parameter int MAX_A_RUN      = 4,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_a_req,
   input  logic        i_a_we,
   input  logic [23:0] i_a_addr,
   input  logic [7:0]  i_a_din,
   output logic        o_a_ack,
   output logic [7:0]  o_a_dout,
   input  logic        i_b_req,
   input  logic        i_b_we,
   input  logic [23:0] i_b_addr,
   input  logic [7:0]  i_b_din,
   output logic        o_b_ack,
   output logic [7:0]  o_b_dout,
   output logic        o_mem_stb,
   output logic        o_mem_we,
   output logic [23:0] o_mem_addr,
   output logic [7:0]  o_mem_din,
   input  logic        i_mem_busy,
   input  logic        i_mem_done,
   input  logic [7:0]  i_mem_dout,
   output logic        o_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_A_RUN);

   state_t      r_state, w_next;
   logic        r_grant_b;   // 0 = A owns the current transaction, 1 = B
   logic        r_b_pend;    // B was waiting when the current grant was made
   logic [3:0]  r_run;       // consecutive A grants taken while B waited
   logic        r_mem_we;
   logic [23:0] r_mem_addr;
   logic [7:0]  r_mem_din;
   logic [7:0]  r_a_dout, r_b_dout;
   logic        w_pick_b, w_tmo, w_finish;
   logic [7:0]  w_rdata;

`ifdef PSRAM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_wcnt;   // holds N during the Nth WAIT cycle

   // WAIT-cycle watchdog counter, restarted every time WAIT is entered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_wcnt <= '0;
      else if (r_state == S_ISSUE)
         r_wcnt <= TW'(1);
      else if (r_state == S_WAIT && r_wcnt != TW'(TIMEOUT_CYCLES))
         r_wcnt <= r_wcnt + 1'b1;
   end

   assign w_tmo = (r_state == S_WAIT) && !i_mem_done && (r_wcnt == TW'(TIMEOUT_CYCLES));
`else
   assign w_tmo = 1'b0;
`endif

   assign w_finish  = (r_state == S_WAIT) && (i_mem_done || w_tmo);
   assign w_rdata   = i_mem_done ? i_mem_dout : 8'hFF;
   assign o_timeout = w_tmo;

   // B wins only when A is absent or A has used up its run allowance
   always_comb begin
      w_pick_b = 1'b0;
      if (i_b_req && (!i_a_req || r_run == RUN_MAX))
         w_pick_b = 1'b1;
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // next-state and strobe/ack decode
   always_comb begin
      w_next    = r_state;
      o_mem_stb = 1'b0;
      o_a_ack   = 1'b0;
      o_b_ack   = 1'b0;
      case (r_state)
         S_IDLE:  if (!i_mem_busy && (i_a_req || i_b_req)) w_next = S_ISSUE;
         S_ISSUE: begin
            o_mem_stb = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT:  if (w_finish) w_next = S_ACK;
         S_ACK:   begin
            o_a_ack = !r_grant_b;
            o_b_ack = r_grant_b;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // capture the winner's command when leaving IDLE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant_b  <= 1'b0;
         r_b_pend   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
      end else if (r_state == S_IDLE && w_next == S_ISSUE) begin
         r_grant_b  <= w_pick_b;
         r_b_pend   <= i_b_req;
         r_mem_we   <= w_pick_b ? i_b_we   : i_a_we;
         r_mem_addr <= w_pick_b ? i_b_addr : i_a_addr;
         r_mem_din  <= w_pick_b ? i_b_din  : i_a_din;
      end
   end

   // return data to the granted port; held until its next completion
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a_dout <= '0;
         r_b_dout <= '0;
      end else if (w_finish) begin
         if (r_grant_b) r_b_dout <= w_rdata;
         else           r_a_dout <= w_rdata;
      end
   end

   // starvation run counter, settled in the ack cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_run <= '0;
      else if (r_state == S_ACK) begin
         if (!r_grant_b && r_b_pend)
            r_run <= (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
         else
            r_run <= '0;
      end
   end

   assign o_mem_we   = r_mem_we;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_din  = r_mem_din;
   assign o_a_dout   = r_a_dout;
   assign o_b_dout   = r_b_dout;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: a small controller model answers strobes
// after a programmable latency, a negedge monitor logs strobes/acks, and one
// task per scenario checks results against hand-computed values.
module tb_psram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_a_req, i_a_we, i_b_req, i_b_we;
   logic [23:0] i_a_addr, i_b_addr;
   logic [7:0]  i_a_din, i_b_din;
   logic        o_a_ack, o_b_ack, o_mem_stb, o_mem_we, o_timeout;
   logic [7:0]  o_a_dout, o_b_dout, o_mem_din;
   logic [23:0] o_mem_addr;
   logic        i_mem_busy, i_mem_done;
   logic [7:0]  i_mem_dout;

   int errors = 0;
   int checks = 0;

   psram_arbiter #(.MAX_A_RUN(4), .TIMEOUT_CYCLES(50)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_din(i_a_din),
      .o_a_ack(o_a_ack), .o_a_dout(o_a_dout),
      .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_addr(i_b_addr), .i_b_din(i_b_din),
      .o_b_ack(o_b_ack), .o_b_dout(o_b_dout),
      .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_din(o_mem_din), .i_mem_busy(i_mem_busy), .i_mem_done(i_mem_done),
      .i_mem_dout(i_mem_dout), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   localparam logic [23:0] ADDR_A = 24'h000A00;
   localparam logic [23:0] ADDR_B = 24'h000B00;
   int stb_n = 0, a_ack_n = 0, b_ack_n = 0, overlap_n = 0, tmo_n = 0;
   int a_ack_cyc, b_ack_cyc, tmo_cyc;
   logic [23:0] stb_addr;
   logic        stb_we;
   logic [7:0]  stb_din;
   int  stb_cyc_q[$];
   bit  grant_q[$];
   bit  ack_q[$];

   always @(negedge clk) begin
      if (o_mem_stb) begin
         stb_n++;
         stb_addr = o_mem_addr;
         stb_we   = o_mem_we;
         stb_din  = o_mem_din;
         stb_cyc_q.push_back(cyc);
         grant_q.push_back(o_mem_addr == ADDR_B);
      end
      if (o_a_ack) begin a_ack_n++; a_ack_cyc = cyc; ack_q.push_back(1'b0); end
      if (o_b_ack) begin b_ack_n++; b_ack_cyc = cyc; ack_q.push_back(1'b1); end
      if (o_a_ack && o_b_ack) overlap_n++;
      if (o_timeout) begin tmo_n++; tmo_cyc = cyc; end
   end

   // ---------------- controller model ----------------
   int         mem_lat   = 4;
   logic [7:0] mem_rdata = 8'h00;
   bit         mem_mute  = 1'b0;
   int         done_cyc;

   initial begin
      i_mem_done = 1'b0;
      i_mem_dout = 8'h00;
      forever begin
         @(negedge clk);
         if (o_mem_stb && !mem_mute) begin
            repeat (mem_lat) @(posedge clk);
            #1;
            i_mem_done = 1'b1;
            i_mem_dout = mem_rdata;
            done_cyc   = cyc;
            @(posedge clk);
            #1;
            i_mem_done = 1'b0;
         end
      end
   end

   // wait (bounded) for an ack on a port, then step past the edge ending it
   task automatic wait_ack(input bit port, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (port ? o_b_ack : o_a_ack) begin ok = 1'b1; break; end
      end
      if (ok) begin @(posedge clk); #1; end
   endtask

   task automatic clear_logs();
      stb_n = 0; a_ack_n = 0; b_ack_n = 0;
      stb_cyc_q.delete(); grant_q.delete(); ack_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_a_ack, o_b_ack, o_mem_stb, o_mem_we, o_mem_addr, o_mem_din, o_a_dout, o_b_dout, o_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: stb=%b addr=%h adout=%h bdout=%h, required all zero",
                  o_mem_stb, o_mem_addr, o_a_dout, o_b_dout);
      end
   endtask

   task automatic test_single_read();
      bit ok;
      clear_logs();
      mem_lat = 20; mem_rdata = 8'h5A;
      @(posedge clk); #1;
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 24'h001234; i_b_din = 8'h00;
      wait_ack(1'b1, ok);
      i_b_req = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL read_ack_timeout: no o_b_ack, required one"); end
      repeat (4) @(negedge clk);
      checks++; if (stb_n !== 1) begin errors++; $display("FAIL read_stb_count: got %0d, required 1", stb_n); end
      checks++; if (stb_addr !== 24'h001234 || stb_we !== 1'b0) begin
         errors++; $display("FAIL read_cmd: addr=%h we=%b, required 001234/0", stb_addr, stb_we); end
      checks++; if (b_ack_cyc !== done_cyc + 1) begin
         errors++; $display("FAIL read_ack_latency: ack cyc %0d, required %0d", b_ack_cyc, done_cyc + 1); end
      checks++; if (o_b_dout !== 8'h5A) begin errors++; $display("FAIL read_dout: got %h, required 5a", o_b_dout); end
      checks++; if (a_ack_n !== 0 || b_ack_n !== 1) begin
         errors++; $display("FAIL read_ack_count: a=%0d b=%0d, required 0/1", a_ack_n, b_ack_n); end
   endtask

   task automatic test_busy_gating();
      bit ok;
      int fall_cyc;
      i_mem_busy = 1'b1;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      clear_logs();
      mem_lat = 6; mem_rdata = 8'h11;
      @(posedge clk); #1;
      i_a_req = 1'b1; i_a_we = 1'b1; i_a_addr = 24'hFFFFFF; i_a_din = 8'hC3;
      repeat (100) @(posedge clk);
      #1;
      checks++; if (stb_n !== 0) begin errors++; $display("FAIL busy_no_stb: got %0d strobes, required 0", stb_n); end
      i_mem_busy = 1'b0;
      fall_cyc = cyc;
      wait_ack(1'b0, ok);
      i_a_req = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL busy_ack_timeout: no o_a_ack, required one"); end
      checks++; if (stb_cyc_q.size() != 1 || stb_cyc_q[0] !== fall_cyc + 1) begin
         errors++; $display("FAIL busy_stb_cycle: count %0d, required one strobe at cyc %0d", stb_cyc_q.size(), fall_cyc + 1); end
      checks++; if (stb_we !== 1'b1 || stb_din !== 8'hC3 || stb_addr !== 24'hFFFFFF) begin
         errors++; $display("FAIL busy_cmd: we=%b din=%h addr=%h, required 1/c3/ffffff", stb_we, stb_din, stb_addr); end
      checks++; if (a_ack_n !== 1) begin errors++; $display("FAIL busy_ack_count: got %0d, required 1", a_ack_n); end
   endtask

   task automatic test_starvation();
      bit exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      bit good;
      clear_logs();
      mem_lat = 4;
      @(posedge clk); #1;
      i_a_we = 1'b0; i_a_addr = ADDR_A; i_a_din = 8'h00;
      i_b_we = 1'b0; i_b_addr = ADDR_B; i_b_din = 8'h00;
      i_a_req = 1'b1; i_b_req = 1'b1;
      fork
         begin
            bit ok;
            for (int n = 0; n < 8; n++) begin
               wait_ack(1'b0, ok);
               if (!ok) begin checks++; errors++; $display("FAIL starve_a_timeout: ack %0d missing", n); break; end
            end
            i_a_req = 1'b0;
         end
         begin
            bit ok;
            for (int n = 0; n < 2; n++) begin
               wait_ack(1'b1, ok);
               if (!ok) begin checks++; errors++; $display("FAIL starve_b_timeout: ack %0d missing", n); break; end
            end
            i_b_req = 1'b0;
         end
      join
      repeat (3) @(negedge clk);
      good = (grant_q.size() == 10);
      if (good) for (int i = 0; i < 10; i++) if (grant_q[i] != exp_order[i]) good = 1'b0;
      checks++; if (!good) begin errors++; $display("FAIL starve_order: %0d grants %p, required AAAABAAAAB", grant_q.size(), grant_q); end
      good = (stb_cyc_q.size() == 10);
      if (good) for (int i = 1; i < 10; i++) if (stb_cyc_q[i] - stb_cyc_q[i-1] != mem_lat + 3) good = 1'b0;
      checks++; if (!good) begin errors++; $display("FAIL starve_spacing: strobe cycles %p, required spacing %0d", stb_cyc_q, mem_lat + 3); end
   endtask

   task automatic test_simultaneous();
      bit good;
      clear_logs();
      mem_lat = 3; mem_rdata = 8'hA7;
      @(posedge clk); #1;
      i_a_addr = ADDR_A; i_b_addr = ADDR_B;
      i_a_req = 1'b1; i_b_req = 1'b1;
      fork
         begin bit ok; wait_ack(1'b0, ok); i_a_req = 1'b0;
            if (!ok) begin checks++; errors++; $display("FAIL simul_a_timeout: no o_a_ack"); end end
         begin bit ok; wait_ack(1'b1, ok); i_b_req = 1'b0;
            if (!ok) begin checks++; errors++; $display("FAIL simul_b_timeout: no o_b_ack"); end end
      join
      repeat (3) @(negedge clk);
      good = grant_q.size() == 2 && grant_q[0] == 1'b0 && grant_q[1] == 1'b1;
      checks++; if (!good) begin errors++; $display("FAIL simul_grant_order: %p, required A then B", grant_q); end
      good = ack_q.size() == 2 && ack_q[0] == 1'b0 && ack_q[1] == 1'b1;
      checks++; if (!good) begin errors++; $display("FAIL simul_ack_order: %p, required A then B", ack_q); end
      checks++; if (o_a_dout !== 8'hA7) begin errors++; $display("FAIL simul_a_dout: got %h, required a7", o_a_dout); end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int b0;
      clear_logs();
      mem_lat = 30; mem_rdata = 8'h99;
      @(posedge clk); #1;
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 24'h00C0DE;
      for (int k = 0; k < 50 && stb_n == 0; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      b0 = b_ack_n;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_a_ack, o_b_ack, o_mem_stb, o_mem_we, o_mem_addr, o_mem_din, o_a_dout, o_b_dout, o_timeout} !== '0) begin
         errors++;
         $display("FAIL rst_async_outputs: addr=%h adout=%h bdout=%h, required all zero", o_mem_addr, o_a_dout, o_b_dout);
      end
      i_b_req = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      checks++; if (b_ack_n !== b0) begin errors++; $display("FAIL rst_no_ack: %0d acks, required 0", b_ack_n - b0); end
      clear_logs();
      mem_lat = 4; mem_rdata = 8'h3C;
      @(posedge clk); #1;
      i_b_req = 1'b1; i_b_addr = 24'h00BEEF;
      wait_ack(1'b1, ok);
      i_b_req = 1'b0;
      checks++; if (!ok || o_b_dout !== 8'h3C || stb_addr !== 24'h00BEEF) begin
         errors++; $display("FAIL rst_fresh_request: ok=%b dout=%h addr=%h, required 1/3c/00beef", ok, o_b_dout, stb_addr); end
   endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int s, n0;
      clear_logs();
      tmo_n = 0;
      mem_mute = 1'b1;
      @(posedge clk); #1;
      i_b_req = 1'b1; i_b_we = 1'b0; i_b_addr = 24'h00FACE;
      wait_ack(1'b1, ok);
      i_b_req = 1'b0;
      s = (stb_cyc_q.size() > 0) ? stb_cyc_q[0] : -100;
      checks++; if (!ok) begin errors++; $display("FAIL tmo_ack_missing: no o_b_ack, required one"); end
      checks++; if (tmo_n !== 1 || tmo_cyc !== s + 50) begin
         errors++; $display("FAIL tmo_pulse: count %0d at cyc %0d, required 1 at %0d", tmo_n, tmo_cyc, s + 50); end
      checks++; if (b_ack_cyc !== s + 51 || o_b_dout !== 8'hFF) begin
         errors++; $display("FAIL tmo_ack: cyc %0d dout %h, required %0d/ff", b_ack_cyc, o_b_dout, s + 51); end
      n0 = a_ack_n + b_ack_n + stb_n;
      i_mem_done = 1'b1; i_mem_dout = 8'h42;
      @(posedge clk); #1;
      i_mem_done = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (a_ack_n + b_ack_n + stb_n !== n0 || o_b_dout !== 8'hFF) begin
         errors++; $display("FAIL tmo_stray_done: activity %0d dout %h, required %0d/ff", a_ack_n + b_ack_n + stb_n, o_b_dout, n0); end
      mem_mute = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; i_mem_busy = 1'b0;
      i_a_req = 1'b0; i_a_we = 1'b0; i_a_addr = '0; i_a_din = '0;
      i_b_req = 1'b0; i_b_we = 1'b0; i_b_addr = '0; i_b_din = '0;
      test_reset();
      test_single_read();
      test_busy_gating();
      test_starvation();
      test_simultaneous();
      test_reset_mid_wait();
`ifdef PSRAM_ARB_TIMEOUT_EN
      test_timeout();
`else
      checks++; if (tmo_n !== 0) begin errors++; $display("FAIL timeout_tied_low: %0d pulses, required 0", tmo_n); end
`endif
      checks++; if (overlap_n !== 0) begin errors++; $display("FAIL ack_overlap: %0d cycles, required 0", overlap_n); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
